// File: rtl/cpubus.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpubus - Dendy CPU bus responder: RAM/PPU/joypad/PRG decode, OAM DMA when
// CPUBUS_DMA_EN is defined.                                        Rev 1.0
// ---------------------------------------------------------------------------
module cpubus #(
   parameter int PRG_BITS = 15
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                ce,
   output logic                cpu_ce,
   input  logic [15:0]         cpu_a,
   input  logic [7:0]          cpu_d,
   input  logic                cpu_r,
   input  logic                cpu_w,
   output logic [7:0]          cpu_i,
   output logic [PRG_BITS-1:0] prg_a,
   input  logic [7:0]          prg_q,
   output logic [2:0]          ppu_a,
   output logic [7:0]          ppu_d,
   input  logic [7:0]          ppu_q,
   output logic                ppu_r,
   output logic                ppu_w,
   input  logic [7:0]          joy1,
   input  logic [7:0]          joy2
);

   typedef enum logic [2:0] {R_OPEN, R_RAM, R_PPU, R_JOY1, R_JOY2, R_PRG} region_t;

   logic [15:0] ba;
   region_t     region_d, region_q;
   logic [7:0]  ram [0:2047];
   logic [7:0]  ram_q, open_q, rd;
   logic [7:0]  sr1_q, sr2_q;
   logic        strobe_q;
   logic        ppu_r_q, ppu_w_q;
   logic [2:0]  ppu_a_q;
   logic [7:0]  ppu_d_q;
   logic        cpu_wr, cpu_rd;
   logic        dma_busy, dma_wr;
   logic [7:0]  dma_d;
   logic [15:0] dma_ba;

`ifdef CPUBUS_DMA_EN
   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_t;

   dma_t       dma_q;
   logic [7:0] page_q, idx_q, latch_q;
   logic       parity_q;

   assign dma_busy = (dma_q != IDLE);
   assign dma_wr   = ce && (dma_q == WRITE);
   assign dma_d    = latch_q;
   assign dma_ba   = {page_q, idx_q};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dma_q    <= IDLE;
         page_q   <= 8'h00;
         idx_q    <= 8'h00;
         latch_q  <= 8'h00;
         parity_q <= 1'b0;
      end else if (ce) begin
         parity_q <= ~parity_q;
         case (dma_q)
            IDLE:  if (cpu_wr && ba == 16'h4014) begin
                      dma_q  <= HALT;
                      page_q <= cpu_d;
                      idx_q  <= 8'h00;
                   end
            HALT:  dma_q <= parity_q ? ALIGN : READ;
            ALIGN: dma_q <= READ;
            READ:  begin
                      latch_q <= rd;
                      dma_q   <= WRITE;
                   end
            WRITE: begin
                      idx_q <= idx_q + 8'd1;
                      dma_q <= (idx_q == 8'hFF) ? IDLE : READ;
                   end
            default: dma_q <= IDLE;
         endcase
      end
   end
`else
   assign dma_busy = 1'b0;
   assign dma_wr   = 1'b0;
   assign dma_d    = 8'h00;
   assign dma_ba   = 16'h0000;
`endif

   assign cpu_ce = ce && !dma_busy;
   assign cpu_wr = cpu_ce && cpu_w;
   assign cpu_rd = cpu_ce && cpu_r;
   assign ba     = dma_busy ? dma_ba : cpu_a;
   assign prg_a  = ba[PRG_BITS-1:0];

   always_comb begin
      region_d = R_OPEN;
      if (ba[15])
         region_d = R_PRG;
      else if (ba[15:13] == 3'b000)
         region_d = R_RAM;
      else if (ba[15:13] == 3'b001)
         region_d = R_PPU;
      else if (ba == 16'h4016)
         region_d = R_JOY1;
      else if (ba == 16'h4017)
         region_d = R_JOY2;
   end

   // Read mux is keyed by the region of the address seen one clock earlier.
   always_comb begin
      case (region_q)
         R_RAM:   rd = ram_q;
         R_PPU:   rd = ppu_q;
         R_JOY1:  rd = {7'b0100000, sr1_q[0]};
         R_JOY2:  rd = {7'b0100000, sr2_q[0]};
         R_PRG:   rd = prg_q;
         default: rd = open_q;
      endcase
   end

   assign cpu_i = rd;

   always_ff @(posedge clock) begin
      if (cpu_wr && region_d == R_RAM)
         ram[ba[10:0]] <= cpu_d;
      ram_q <= ram[ba[10:0]];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         region_q <= R_OPEN;
         open_q   <= 8'h00;
         sr1_q    <= 8'h00;
         sr2_q    <= 8'h00;
         strobe_q <= 1'b0;
         ppu_r_q  <= 1'b0;
         ppu_w_q  <= 1'b0;
         ppu_a_q  <= 3'd0;
         ppu_d_q  <= 8'h00;
      end else begin
         region_q <= region_d;
         open_q   <= rd;
         ppu_r_q  <= 1'b0;
         ppu_w_q  <= 1'b0;
         if (cpu_wr && region_d == R_PPU) begin
            ppu_w_q <= 1'b1;
            ppu_a_q <= ba[2:0];
            ppu_d_q <= cpu_d;
         end else if (cpu_rd && region_d == R_PPU) begin
            ppu_r_q <= 1'b1;
            ppu_a_q <= ba[2:0];
         end else if (dma_wr) begin
            ppu_w_q <= 1'b1;
            ppu_a_q <= 3'd4;
            ppu_d_q <= dma_d;
         end
         if (cpu_wr && ba == 16'h4016)
            strobe_q <= cpu_d[0];
         // The CPU samples bit0 on the committing edge; the shift lands after it.
         if (strobe_q) begin
            sr1_q <= joy1;
            sr2_q <= joy2;
         end else begin
            if (cpu_rd && region_d == R_JOY1)
               sr1_q <= {1'b1, sr1_q[7:1]};
            if (cpu_rd && region_d == R_JOY2)
               sr2_q <= {1'b1, sr2_q[7:1]};
         end
      end
   end

   assign ppu_r = ppu_r_q;
   assign ppu_w = ppu_w_q;
   assign ppu_a = ppu_a_q;
   assign ppu_d = ppu_d_q;

endmodule
`default_nettype wire

// File: tb/tb_cpubus.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cpubus - directed self-checking bench for cpubus.             Rev 1.0
// ---------------------------------------------------------------------------
module tb_cpubus;

   logic        clock = 1'b0;
   logic        reset, ce, cpu_ce, cpu_r, cpu_w, ppu_r, ppu_w;
   logic [15:0] cpu_a;
   logic [7:0]  cpu_d, cpu_i, prg_q, ppu_d, ppu_q, joy1, joy2;
   logic [14:0] prg_a;
   logic [2:0]  ppu_a;

   cpubus #(.PRG_BITS(15)) dut (
      .clock(clock), .reset(reset), .ce(ce), .cpu_ce(cpu_ce),
      .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_r(cpu_r), .cpu_w(cpu_w), .cpu_i(cpu_i),
      .prg_a(prg_a), .prg_q(prg_q),
      .ppu_a(ppu_a), .ppu_d(ppu_d), .ppu_q(ppu_q), .ppu_r(ppu_r), .ppu_w(ppu_w),
      .joy1(joy1), .joy2(joy2)
   );

   always #5 clock = ~clock;

   // PRG ROM model: synchronous, one clock of latency.
   always @(posedge clock) prg_q <= prg_a[7:0] ^ {1'b0, prg_a[14:8]};

   int         w_cnt = 0, r_cnt = 0;
   logic [7:0] w_d [0:4095];
   logic [2:0] w_a [0:4095];

   always @(negedge clock) begin
      if (ppu_w) begin
         if (w_cnt < 4096) begin
            w_d[w_cnt] = ppu_d;
            w_a[w_cnt] = ppu_a;
         end
         w_cnt++;
      end
      if (ppu_r) r_cnt++;
   end

   int         n_chk = 0, n_fail = 0;
   int         gated = 0, ntick = 0;
   logic       last_ce;
   logic [7:0] rd_v;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One CPU cycle: address presented, data sampled a clock later, commit on the ce edge.
   task automatic bus(input logic [15:0] a, input logic r, input logic w, input logic [7:0] d);
      cpu_a = a; cpu_r = r; cpu_w = w; cpu_d = d; ce = 1'b0;
      @(posedge clock); #1;
      rd_v = cpu_i;
      ce = 1'b1; #1;
      last_ce = cpu_ce;
      if (!cpu_ce) gated++;
      @(posedge clock); #1;
      ce = 1'b0;
      ntick++;
   endtask

   task automatic reset_checks(input string p);
      check({p, "_cpu_i"}, 32'(cpu_i), 32'h00);
      check({p, "_ppu_r"}, 32'(ppu_r), 32'h0);
      check({p, "_ppu_w"}, 32'(ppu_w), 32'h0);
      check({p, "_ppu_a"}, 32'(ppu_a), 32'h0);
      check({p, "_ppu_d"}, 32'(ppu_d), 32'h00);
      check({p, "_prg_a"}, 32'(prg_a), 32'h0);
      ce = 1'b1; #1;
      check({p, "_cpu_ce_hi"}, 32'(cpu_ce), 32'h1);
      ce = 1'b0; #1;
      check({p, "_cpu_ce_lo"}, 32'(cpu_ce), 32'h0);
   endtask

   initial begin
      int         b0, g0, r0, bad;
      logic [9:0] seq;
      reset = 1'b1; ce = 1'b0; cpu_a = 16'h0000; cpu_d = 8'h00; cpu_r = 1'b0; cpu_w = 1'b0;
      ppu_q = 8'hA7; joy1 = 8'h81; joy2 = 8'h02;
      repeat (3) @(posedge clock);
      #1;
      reset_checks("rst");
      reset = 1'b0;
      ntick = 0;

      // RAM mirroring and open bus
      bus(16'h0012, 1'b0, 1'b1, 8'h55);
      bus(16'h0812, 1'b1, 1'b0, 8'h00); check("ram_0812", 32'(rd_v), 32'h55);
      bus(16'h1012, 1'b1, 1'b0, 8'h00); check("ram_1012", 32'(rd_v), 32'h55);
      bus(16'h1812, 1'b1, 1'b0, 8'h00); check("ram_1812", 32'(rd_v), 32'h55);
      bus(16'h5000, 1'b1, 1'b0, 8'h00); check("open_bus", 32'(rd_v), 32'h55);

      // PPU register mirroring
      b0 = w_cnt; r0 = r_cnt;
      bus(16'h2000, 1'b0, 1'b1, 8'h80);
      check("ppu_w_pulse", 32'(ppu_w), 32'h1);
      check("ppu_w_a", 32'(ppu_a), 32'h0);
      check("ppu_w_d", 32'(ppu_d), 32'h80);
      bus(16'h3FFA, 1'b1, 1'b0, 8'h00);
      check("ppu_rd_data", 32'(rd_v), 32'hA7);
      check("ppu_r_pulse", 32'(ppu_r), 32'h1);
      check("ppu_r_a", 32'(ppu_a), 32'h2);
      bus(16'h0000, 1'b0, 1'b0, 8'h00);
      check("ppu_r_clear", 32'(ppu_r), 32'h0);
      check("ppu_w_count", 32'(w_cnt - b0), 32'd1);
      check("ppu_r_count", 32'(r_cnt - r0), 32'd1);

      // PRG ROM: 32 KB, $8005 and $C005 are distinct
      bus(16'h8005, 1'b1, 1'b0, 8'h00); check("prg_8005", 32'(rd_v), 32'h05);
      bus(16'hC005, 1'b1, 1'b0, 8'h00); check("prg_c005", 32'(rd_v), 32'h45);

      // Joypads
      bus(16'h4016, 1'b0, 1'b1, 8'h01);
      bus(16'h4016, 1'b0, 1'b1, 8'h00);
      seq = 10'b1110000001;
      for (int i = 0; i < 10; i++) begin
         bus(16'h4016, 1'b1, 1'b0, 8'h00);
         check($sformatf("joy1_rd%0d", i), 32'(rd_v), 32'({7'b0100000, seq[i]}));
      end
      bus(16'h4017, 1'b1, 1'b0, 8'h00); check("joy2_rd0", 32'(rd_v), 32'h40);
      bus(16'h4017, 1'b1, 1'b0, 8'h00); check("joy2_rd1", 32'(rd_v), 32'h41);

`ifdef CPUBUS_DMA_EN
      for (int i = 0; i < 256; i++) bus(16'h0200 + 16'(i), 1'b0, 1'b1, 8'(i));

      // Two full DMAs: HALT seen at parity 0, then at parity 1
      for (int pass = 0; pass < 2; pass++) begin
         if (((ntick + 1) % 2) != pass) bus(16'h0000, 1'b0, 1'b0, 8'h00);
         bus(16'h4014, 1'b0, 1'b1, 8'h02);
         check($sformatf("dma%0d_start_ce", pass), 32'(last_ce), 32'h1);
         b0 = w_cnt; g0 = gated;
         for (int k = 0; k < 600; k++) begin
            bus(16'h0000, 1'b0, 1'b0, 8'h00);
            if (last_ce) break;
         end
         check($sformatf("dma%0d_done", pass), 32'(last_ce), 32'h1);
         check($sformatf("dma%0d_stall", pass), 32'(gated - g0), 32'(513 + pass));
         check($sformatf("dma%0d_pulses", pass), 32'(w_cnt - b0), 32'd256);
         bad = 0;
         for (int i = 0; i < 256; i++)
            if (w_d[b0 + i] !== 8'(i) || w_a[b0 + i] !== 3'd4) bad++;
         check($sformatf("dma%0d_data_errs", pass), 32'(bad), 32'd0);
      end

      // Reset in the middle of a DMA
      bus(16'h4014, 1'b0, 1'b1, 8'h02);
      b0 = w_cnt;
      for (int k = 0; k < 400; k++) begin
         bus(16'h0000, 1'b0, 1'b0, 8'h00);
         if (w_cnt - b0 >= 100) break;
      end
      check("mid_dma_pulses", 32'(w_cnt - b0), 32'd100);
      reset = 1'b1; #1;
      reset_checks("mid_rst");
      @(posedge clock); #1;
      reset = 1'b0;
      b0 = w_cnt; g0 = gated;
      bus(16'h0000, 1'b0, 1'b0, 8'h00);
      check("mid_rst_first_ce", 32'(last_ce), 32'h1);
      repeat (600) bus(16'h0000, 1'b0, 1'b0, 8'h00);
      check("mid_rst_no_ppu_w", 32'(w_cnt - b0), 32'd0);
      check("mid_rst_no_gate", 32'(gated - g0), 32'd0);
`else
      // No DMA engine: $4014 writes are ignored
      b0 = w_cnt; g0 = gated;
      bus(16'h4014, 1'b0, 1'b1, 8'h02);
      repeat (600) bus(16'h0000, 1'b0, 1'b0, 8'h00);
      check("nodma_ppu_w", 32'(w_cnt - b0), 32'd0);
      check("nodma_gated", 32'(gated - g0), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
